inst_prefetch_queue: RTL

- Instruction fetch front end between the instruction memory (1-cycle synchronous read) and the CPU decode stage.
- Owns the fetch PC and drives the instruction-memory address.
- Buffers returned instruction words in a small FIFO, with PC tags.
- Presents them to decode over a valid/ready handshake; a redirect (branch/jump) flushes everything and restarts fetch.

---
 rtl/inst_fetch_pkg.sv | 19 +
 rtl/inst_prefetch_queue_if.sv | 42 ++++
 rtl/inst_prefetch_queue_fifo.sv | 74 +++++++
 rtl/inst_prefetch_queue.sv | 126 ++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared defaults and the FSM state encoding for the instruction prefetch queue.
// No ports; imported by the interface, the FIFO and the top.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

   localparam int          IPQ_ADDR_W   = 32;
   localparam int          IPQ_INST_W   = 32;
   localparam int          IPQ_PC_INC   = 4;
   localparam logic [31:0] IPQ_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } ipq_state_e;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue_if
// Groups the three buses around the prefetch queue:
//   imem side     : imem_addr, imem_req (to memory), imem_data (from memory)
//   redirect side : redirect_valid, redirect_addr
//   decode side   : inst_valid, inst, inst_pc (to decode), inst_ready (from decode)
// master = prefetch queue, slave = memory/decode/branch environment.
// -----------------------------------------------------------------------------
interface inst_prefetch_queue_if
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_W = IPQ_ADDR_W,
   parameter int INST_W = IPQ_INST_W
) ();

   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req;
   logic [INST_W-1:0] imem_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              inst_valid;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic              inst_ready;

   modport master (
      output imem_addr, imem_req,
      input  imem_data,
      input  redirect_valid, redirect_addr,
      output inst_valid, inst, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_addr, imem_req,
      output imem_data,
      output redirect_valid, redirect_addr,
      input  inst_valid, inst, inst_pc,
      output inst_ready
   );

endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// ipq_fifo
// Generic DEPTH x WIDTH synchronous FIFO with combinational head.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   i_push     write i_wdata at the tail
//   i_pop      advance head (ignored when empty)
//   i_clear    synchronous flush; wins over push/pop
//   o_head     head entry
//   o_count    occupancy 0..DEPTH
//   o_empty    occupancy is zero
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module ipq_fifo
   import inst_fetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_clear,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_head,
   output logic [AW:0]      o_count,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_pop;
   logic             w_full;

   assign o_empty  = (r_count == '0);
   assign w_full   = (r_count == (AW+1)'(DEPTH));
   assign w_do_pop = i_pop && !o_empty;
   assign o_head   = r_mem[r_rd_ptr];
   assign o_count  = r_count;

   // Storage is reset too so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The upstream credit scheme must never push into a full queue.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(i_push && !i_clear && w_full && !w_do_pop));

endmodule

// File: rtl/inst_prefetch_queue.sv
// -----------------------------------------------------------------------------
// inst_prefetch_queue
// Instruction fetch front end: owns the fetch PC, issues 1-cycle synchronous
// memory reads, buffers returned words with their PC in ipq_fifo and hands
// them to decode over valid/ready. A redirect flushes and restarts fetch.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   inst_prefetch_queue_if.master (imem, redirect, decode buses)
// Build option:
//   IPQ_BYPASS_EN  when defined, a return arriving at an empty queue is shown
//                  to decode in the same cycle (1-cycle issue-to-valid);
//                  otherwise every return goes through the FIFO (2 cycles).
// -----------------------------------------------------------------------------
module inst_prefetch_queue
   import inst_fetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = IPQ_ADDR_W,
   parameter int                INST_W   = IPQ_INST_W,
   parameter int                PC_INC   = IPQ_PC_INC,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IPQ_RESET_PC)
) (
   input logic                   clk,
   input logic                   rst,
   inst_prefetch_queue_if.master bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = INST_W + ADDR_W;

   ipq_state_e        r_state;
   ipq_state_e        w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_req_pc;
   logic              r_inflight;   // a read return is on imem_data this cycle
   logic              w_issue;
   logic              w_redir;
   logic              w_ret;
   logic              w_byp;
   logic              w_byp_take;
   logic              w_push;
   logic              w_pop;
   logic [AW:0]       w_count;
   logic              w_empty;
   logic [FW-1:0]     w_head;

   assign w_redir = bus.redirect_valid;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_BOOT;
      else      r_state <= w_state_nxt;
   end

   // Credit: occupancy plus the outstanding return must leave a free slot,
   // so the return always has room and needs no backpressure path.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ST_BOOT:  w_state_nxt = ST_RUN;
         ST_RUN:   w_issue     = (int'(w_count) + int'(r_inflight)) < DEPTH;
         ST_FLUSH: w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_BOOT;
      endcase
      if (w_redir) w_state_nxt = ST_FLUSH;
   end

   // ---------------- fetch PC / inflight tracking ----------------
   // A redirect kills whatever return is due next cycle by clearing r_inflight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
      end else if (w_redir) begin
         r_fetch_pc <= bus.redirect_addr;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_INC);
         end
      end
   end

   assign bus.imem_addr = r_fetch_pc;
   assign bus.imem_req  = w_issue;

   // ---------------- return / decode side ----------------
   // A return in the redirect cycle belongs to the old stream and is dropped.
   assign w_ret = r_inflight && !w_redir;

`ifdef IPQ_BYPASS_EN
   assign w_byp      = w_ret && w_empty;
   assign w_byp_take = w_byp && bus.inst_ready;
`else
   assign w_byp      = 1'b0;
   assign w_byp_take = 1'b0;
`endif

   assign w_push = w_ret && !w_byp_take;
   assign w_pop  = !w_empty && bus.inst_ready && !w_redir;

   assign bus.inst_valid = !w_redir && (!w_empty || w_byp);
   assign bus.inst       = w_byp ? bus.imem_data : w_head[FW-1:ADDR_W];
   assign bus.inst_pc    = w_byp ? r_req_pc      : w_head[ADDR_W-1:0];

   ipq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_redir),
      .i_wdata ({bus.imem_data, r_req_pc}),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

endmodule
